// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM states, default device address
// and the R/W bit encoding used by both ends of the configuration bus.
package iic_pkg;

    localparam logic [6:0] IIC_DEV_ADDR_DEFAULT = 7'h48;

    localparam logic IIC_RW_WRITE = 1'b0;
    localparam logic IIC_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEVADR,
        ST_DEVACK,
        ST_REGADR,
        ST_REGACK,
        ST_WRDATA,
        ST_WRACK,
        ST_RDDATA,
        ST_RDACK,
        ST_IGNORE
    } iic_state_e;

endpackage

// File: rtl/iic_line_filter.sv
// Conditions one raw I2C pad line: 2-flop synchronizer, FILT-deep glitch
// filter, and one-cycle rise/fall pulses aligned with the filtered output.
// Ports: clk, rst (async high), line_i (raw), line_o (filtered), rise, fall.
module iic_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o,
    output logic rise,
    output logic fall
);

    logic [1:0]      sync;
    logic [FILT-1:0] hist;

    // The bus idles high, so every stage resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= 2'b11;
            hist   <= '1;
            line_o <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync <= {sync[0], line_i};
            hist <= (hist << 1) | FILT'(sync[1]);
            rise <= 1'b0;
            fall <= 1'b0;
            if ((&hist) && !line_o) begin
                line_o <= 1'b1;
                rise   <= 1'b1;
            end else if (!(|hist) && line_o) begin
                line_o <= 1'b0;
                fall   <= 1'b0 | 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target bridging bus transactions onto a simple register port with
// an auto-incrementing pointer.
// Ports: clk, rst (async high), scl_i/sda_i (raw pads), sda_oe (open-drain
// pull-down), reg_addr/reg_wdata/reg_we/reg_re/reg_rdata, busy.
module iic_slave_regs
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = IIC_DEV_ADDR_DEFAULT,
    parameter int         AW       = 8,
    parameter int         FILT     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic          busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    iic_line_filter #(.FILT(FILT)) u_scl (
        .clk    (clk),
        .rst    (rst),
        .line_i (scl_i),
        .line_o (scl_f),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    iic_line_filter #(.FILT(FILT)) u_sda (
        .clk    (clk),
        .rst    (rst),
        .line_i (sda_i),
        .line_o (sda_f),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // SCL is unchanged while the SDA edge is seen, so the current level
    // of scl_f tells a START/STOP apart from ordinary data transitions.
    logic start_det, stop_det;
    assign start_det = sda_fall && scl_f;
    assign stop_det  = sda_rise && scl_f;

    iic_state_e    state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          ptr_inc, ptr_inc_n;
    logic          rw, rw_n;
    logic          busy_n, sda_oe_n;
    logic [AW-1:0] reg_addr_n;
    logic [7:0]    reg_wdata_n;
    logic          reg_we_n, reg_re_n;
    logic [7:0]    byte_in;

    assign byte_in = {sh[6:0], sda_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            ptr_inc   <= 1'b0;
            rw        <= IIC_RW_WRITE;
            busy      <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            ptr_inc   <= ptr_inc_n;
            rw        <= rw_n;
            busy      <= busy_n;
            sda_oe    <= sda_oe_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            reg_re    <= reg_re_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sh_n        = sh;
        ptr_n       = ptr;
        ptr_inc_n   = 1'b0;
        rw_n        = rw;
        busy_n      = busy;
        sda_oe_n    = sda_oe;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        reg_re_n    = 1'b0;

        if (ptr_inc) begin
            ptr_n = ptr + AW'(1);
        end
        // Read data arrives one cycle after the strobe.
        if (reg_re) begin
            sh_n = reg_rdata;
        end

        if (start_det) begin
            state_n  = ST_DEVADR;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
        end else if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_IGNORE: begin
                end
                ST_DEVADR: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            if (byte_in[7:1] == DEV_ADDR) begin
                                busy_n  = 1'b1;
                                rw_n    = byte_in[0];
                                state_n = ST_DEVACK;
                                if (byte_in[0] == IIC_RW_READ) begin
                                    reg_re_n   = 1'b1;
                                    reg_addr_n = ptr;
                                end
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end
                    end
                end
                // sda_oe doubles as the ACK phase flag: the first fall
                // pulls SDA low, the second one ends the ACK bit.
                ST_DEVACK, ST_REGACK, ST_WRACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else if (state == ST_DEVACK &&
                                     rw == IIC_RW_READ) begin
                            state_n  = ST_RDDATA;
                            sda_oe_n = ~sh[7];
                            sh_n     = {sh[6:0], 1'b0};
                            cnt_n    = 4'd1;
                        end else begin
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            state_n  = (state == ST_DEVACK) ?
                                       ST_REGADR : ST_WRDATA;
                        end
                    end
                end
                ST_REGADR: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            ptr_n   = AW'(byte_in);
                            state_n = ST_REGACK;
                        end
                    end
                end
                ST_WRDATA: begin
                    if (scl_rise) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n       = '0;
                            reg_we_n    = 1'b1;
                            reg_addr_n  = ptr;
                            reg_wdata_n = byte_in;
                            ptr_inc_n   = 1'b1;
                            state_n     = ST_WRACK;
                        end
                    end
                end
                // cnt counts bits already placed on the bus.
                ST_RDDATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe_n  = 1'b0;
                            ptr_inc_n = 1'b1;
                            state_n   = ST_RDACK;
                        end else begin
                            sda_oe_n = ~sh[7];
                            sh_n     = {sh[6:0], 1'b0};
                            cnt_n    = cnt + 4'd1;
                        end
                    end
                end
                ST_RDACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            reg_re_n   = 1'b1;
                            reg_addr_n = ptr;
                            cnt_n      = '0;
                            state_n    = ST_RDDATA;
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: a timed bus-model master drives SCL/SDA
// and each scenario task checks ACKs, register strobes and read data.
module tb_iic_slave_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    wire        sda_bus = sda_m & ~sda_oe;

    logic [7:0]  mem [256];
    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    assign reg_rdata = mem[reg_addr];

    iic_slave_regs dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
    end

    task automatic send_bit(input logic v, input logic g, output logic s);
        if (g) begin
            #60 scl = 1'b1;
            #20 scl = 1'b0;
            #20;
        end else begin
            #100;
        end
        sda_m = v;
        #100 scl = 1'b1;
        #100 s = sda_bus;
        #100 scl = 1'b0;
    endtask

    task automatic i2c_start();
        #100 sda_m = 1'b1;
        #100 scl = 1'b1;
        #100 sda_m = 1'b0;
        #100 scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #100 sda_m = 1'b0;
        #100 scl = 1'b1;
        #100 sda_m = 1'b1;
        #200;
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit,
                              output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], (i == gbit), s);
        end
        send_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        send_bit(~ack, 1'b0, s);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe got %b want 0", sda_oe); else passed++;
        checks++; if (reg_we !== 1'b0) $display("FAIL rst_we got %b want 0", reg_we); else passed++;
        checks++; if (reg_re !== 1'b0) $display("FAIL rst_re got %b want 0", reg_re); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        checks++; if (reg_addr !== 8'h00) $display("FAIL rst_addr got %h want 00", reg_addr); else passed++;
        checks++; if (reg_wdata !== 8'h00) $display("FAIL rst_wdata got %h want 00", reg_wdata); else passed++;
    endtask

    task automatic test_write_single();
        logic a0, a1, a2, a3;
        logic [7:0] b;
        we_q.delete(); re_q.delete();
        i2c_start();
        write_byte(8'h90, -1, a0);
        write_byte(8'h51, -1, a1);
        write_byte(8'h00, -1, a2);
        checks++; if ({a0, a1, a2} !== 3'b111) $display("FAIL ws_acks got %b want 111", {a0, a1, a2}); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL ws_busy got %b want 1", busy); else passed++;
        i2c_stop();
        checks++; if (busy !== 1'b0) $display("FAIL ws_busy_stop got %b want 0", busy); else passed++;
        checks++; if (we_q.size() != 1) $display("FAIL ws_we_count got %0d want 1", we_q.size()); else passed++;
        checks++; if ((we_q.size() > 0 ? we_q[0] : 16'hxxxx) !== 16'h5100) $display("FAIL ws_we got %h want 5100", (we_q.size() > 0 ? we_q[0] : 16'hxxxx)); else passed++;
        i2c_start();
        write_byte(8'h91, -1, a3);
        read_byte(1'b0, b);
        i2c_stop();
        checks++; if ((re_q.size() > 0 ? re_q[0] : 8'hxx) !== 8'h52) $display("FAIL ws_ptr got %h want 52", (re_q.size() > 0 ? re_q[0] : 8'hxx)); else passed++;
        checks++; if (b !== 8'hD5) $display("FAIL ws_rd got %h want d5", b); else passed++;
    endtask

    task automatic test_back_to_back();
        logic a;
        logic [3:0] acks;
        we_q.delete(); re_q.delete();
        i2c_start();
        write_byte(8'h90, -1, acks[0]);
        write_byte(8'h65, -1, acks[1]);
        write_byte(8'hAA, -1, acks[2]);
        write_byte(8'hBB, -1, acks[3]);
        i2c_stop();
        checks++; if (acks !== 4'hF) $display("FAIL bb_acks got %b want 1111", acks); else passed++;
        checks++; if (we_q.size() != 2) $display("FAIL bb_we_count got %0d want 2", we_q.size()); else passed++;
        checks++; if ((we_q.size() > 1 ? {we_q[0], we_q[1]} : 32'hx) !== 32'h65AA_66BB) $display("FAIL bb_we got %h want 65aa66bb", (we_q.size() > 1 ? {we_q[0], we_q[1]} : 32'hx)); else passed++;
        we_q.delete();
        i2c_start();
        write_byte(8'h90, -1, a);
        write_byte(8'hFF, -1, a);
        write_byte(8'h11, -1, a);
        write_byte(8'h22, -1, a);
        i2c_stop();
        checks++; if ((we_q.size() > 1 ? {we_q[0], we_q[1]} : 32'hx) !== 32'hFF11_0022) $display("FAIL bb_wrap got %h want ff110022", (we_q.size() > 1 ? {we_q[0], we_q[1]} : 32'hx)); else passed++;
    endtask

    task automatic test_read();
        logic [2:0] acks;
        logic [7:0] b0, b1;
        we_q.delete(); re_q.delete();
        i2c_start();
        write_byte(8'h90, -1, acks[0]);
        write_byte(8'h71, -1, acks[1]);
        i2c_start();
        write_byte(8'h91, -1, acks[2]);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        #100;
        checks++; if (acks !== 3'b111) $display("FAIL rd_acks got %b want 111", acks); else passed++;
        checks++; if (b0 !== 8'h08) $display("FAIL rd_byte0 got %h want 08", b0); else passed++;
        checks++; if (b1 !== 8'h3C) $display("FAIL rd_byte1 got %h want 3c", b1); else passed++;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rd_nack_release got %b want 0", sda_oe); else passed++;
        i2c_stop();
        checks++; if (re_q.size() != 2) $display("FAIL rd_re_count got %0d want 2", re_q.size()); else passed++;
        checks++; if ((re_q.size() > 1 ? {re_q[0], re_q[1]} : 16'hx) !== 16'h7172) $display("FAIL rd_re_addr got %h want 7172", (re_q.size() > 1 ? {re_q[0], re_q[1]} : 16'hx)); else passed++;
        checks++; if (we_q.size() != 0) $display("FAIL rd_no_we got %0d want 0", we_q.size()); else passed++;
    endtask

    task automatic test_bad_addr();
        logic a;
        we_q.delete(); re_q.delete();
        i2c_start();
        write_byte(8'hA0, -1, a);
        checks++; if (a !== 1'b0) $display("FAIL ba_ack got %b want 0", a); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL ba_busy got %b want 0", busy); else passed++;
        i2c_stop();
        checks++; if (we_q.size() + re_q.size() != 0) $display("FAIL ba_strobes got %0d want 0", we_q.size() + re_q.size()); else passed++;
    endtask

    task automatic test_partial_stop();
        logic a0, a1, s;
        logic [2:0] acks;
        we_q.delete(); re_q.delete();
        i2c_start();
        write_byte(8'h90, -1, a0);
        write_byte(8'h30, -1, a1);
        send_bit(1'b1, 1'b0, s);
        send_bit(1'b0, 1'b0, s);
        send_bit(1'b1, 1'b0, s);
        send_bit(1'b1, 1'b0, s);
        i2c_stop();
        checks++; if (we_q.size() != 0) $display("FAIL ps_no_we got %0d want 0", we_q.size()); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL ps_busy got %b want 0", busy); else passed++;
        i2c_start();
        write_byte(8'h90, -1, acks[0]);
        write_byte(8'h40, -1, acks[1]);
        write_byte(8'h5A, -1, acks[2]);
        i2c_stop();
        checks++; if (acks !== 3'b111) $display("FAIL ps_next_acks got %b want 111", acks); else passed++;
        checks++; if ((we_q.size() == 1 ? we_q[0] : 16'hx) !== 16'h405A) $display("FAIL ps_next_we got %h want 405a", (we_q.size() == 1 ? we_q[0] : 16'hx)); else passed++;
    endtask

    task automatic test_glitch();
        logic [2:0] acks;
        we_q.delete();
        i2c_start();
        write_byte(8'h90, -1, acks[0]);
        write_byte(8'h20, -1, acks[1]);
        write_byte(8'hC3, 3, acks[2]);
        i2c_stop();
        checks++; if (acks !== 3'b111) $display("FAIL gl_acks got %b want 111", acks); else passed++;
        checks++; if ((we_q.size() == 1 ? we_q[0] : 16'hx) !== 16'h20C3) $display("FAIL gl_we got %h want 20c3", (we_q.size() == 1 ? we_q[0] : 16'hx)); else passed++;
    endtask

    task automatic test_reset_midread();
        logic a, s;
        logic [2:0] acks;
        i2c_start();
        write_byte(8'h90, -1, a);
        write_byte(8'h80, -1, a);
        i2c_start();
        write_byte(8'h91, -1, a);
        send_bit(1'b1, 1'b0, s);
        send_bit(1'b1, 1'b0, s);
        #100 scl = 1'b1;
        #50;
        checks++; if (sda_oe !== 1'b1) $display("FAIL rm_driving got %b want 1", sda_oe); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rm_sda_oe got %b want 0", sda_oe); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rm_busy got %b want 0", busy); else passed++;
        #99 rst = 1'b0;
        sda_m = 1'b1;
        #400;
        we_q.delete();
        i2c_start();
        write_byte(8'h90, -1, acks[0]);
        write_byte(8'h05, -1, acks[1]);
        write_byte(8'h77, -1, acks[2]);
        i2c_stop();
        checks++; if (acks !== 3'b111) $display("FAIL rm_next_acks got %b want 111", acks); else passed++;
        checks++; if ((we_q.size() == 1 ? we_q[0] : 16'hx) !== 16'h0577) $display("FAIL rm_next_we got %h want 0577", (we_q.size() == 1 ? we_q[0] : 16'hx)); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h52] = 8'hD5;
        mem[8'h71] = 8'h08;
        mem[8'h72] = 8'h3C;
        mem[8'h80] = 8'h00;
        #100 rst = 1'b0;
        #100;
        test_reset();
        test_write_single();
        test_back_to_back();
        test_read();
        test_bad_addr();
        test_partial_stop();
        test_glitch();
        test_reset_midread();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
